denoise_frame_sequencer: RTL and testbench
==========================================

# denoise_frame_sequencer

Frame-level controller for the noise-estimation + Wiener denoising pipeline. It turns writer and reader status into the enable and strobe inputs of `noise_estimation` and `wiener_3_channels`: `start_of_frame_*`, `start_data_*`, `noise_estimation_en`, `wiener_block_stats_en` and `wiener_calc_en`. It sits beside the stream/memory top and replaces the externally driven control pins. It sequences one frame at a time: noise pass over every block, then a stats pass and a calc pass for each block.

## Interface
- `BLOCK_SIZE`, default 8: block edge in pixels. Beats per block is `SPB = BLOCK_SIZE*BLOCK_SIZE`, a power of 2.
- `CNT_WIDTH`, default 16: width of `frame_count`.
- `clk`, in, 1: single clock for the block.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `enable`, in, 1: permits a new frame to start. Sampled only in IDLE.
- `blocks_per_frame`, in, 32: number of blocks per frame. Sampled on frame start.
- `frame_ready_for_noise_est`, in, 1: 1-cycle pulse from `memory_writer`.
- `rvalid`, in, 1: read beat accepted on the noise-estimation read port.
- `estimated_noise_ready`, in, 1: pulse from `noise_estimation`.
- `rvalid_2`, in, 1: read beat accepted on the Wiener read port.
- `end_of_frame_wiener`, in, 1: pulse from `memory_reader_wiener`.
- `noise_estimation_en`, out, 1: clock-enable for `noise_estimation`.
- `start_of_frame_noise_estimation`, out, 1: 1-cycle strobe.
- `start_data_noise_est`, out, 1: strobe on the first beat of each block.
- `start_of_frame_wiener`, out, 1: 1-cycle strobe.
- `start_data_wiener`, out, 1: strobe on the first beat of each stats pass.
- `wiener_block_stats_en`, out, 1: level, high for the whole stats pass.
- `wiener_calc_en`, out, 1: level, high for the whole calc pass.
- `busy`, out, 1: high whenever state ≠ IDLE.
- `frame_done`, out, 1: 1-cycle pulse at frame completion.
- `frame_count`, out, `CNT_WIDTH`: number of completed frames. Wraps.
- `overrun`, out, 1: sticky. Frame-ready pulse arrived while busy.
- `seq_error`, out, 1: sticky. `blocks_per_frame==0`, or early `end_of_frame_wiener`.

## Operation

**States:** IDLE, NE_SOF, NE_RUN, W_SOF, W_STATS, W_CALC, DONE.

**IDLE**
- On `enable && frame_ready_for_noise_est`: latch `blocks_per_frame` into `nblk`.
- If `nblk` is 0, set `seq_error` and stay in IDLE.
- Otherwise go to NE_SOF.
- With `enable` low, the pulse is ignored and no flag is set.

**NE_SOF**
- `start_of_frame_noise_estimation`=1 for this one cycle.
- Clear `beat_cnt` (log2(SPB) bits) and `blk_cnt` (32 bits).
- Next state: NE_RUN.

**NE_RUN**
- Each `rvalid` increments `beat_cnt`, modulo SPB.
- `start_data_noise_est` = `rvalid && beat_cnt==0`.
- `estimated_noise_ready` moves to W_SOF.

**Noise enable**
- `noise_estimation_en` is 1 in NE_SOF and NE_RUN.
- It is also 1 in the W_SOF cycle, so the ready pulse completes inside the gated domain.

**W_SOF**
- `start_of_frame_wiener`=1 for one cycle.
- Clear `beat_cnt` and `blk_cnt`.
- Next state: W_STATS.

**W_STATS**
- `wiener_block_stats_en`=1.
- `start_data_wiener` = `rvalid_2 && beat_cnt==0`.
- The `rvalid_2` beat with `beat_cnt==SPB-1` moves to W_CALC, with `beat_cnt` reset to 0.

**W_CALC**
- `wiener_calc_en`=1.
- The beat with `beat_cnt==SPB-1` increments `blk_cnt`.
- If `blk_cnt==nblk-1`, go to DONE. Otherwise go to W_STATS.

**DONE**
- `frame_done`=1 and `frame_count`+1.
- Next state: IDLE.

**Boundary and error rules**
- `end_of_frame_wiener` in W_STATS or W_CALC before the final calc beat: set `seq_error` and go to DONE.
- `end_of_frame_wiener` on the final calc beat is normal and sets no flag.
- `frame_ready_for_noise_est` in any non-IDLE state: set `overrun`. The frame is not queued and the current frame continues.
- `enable` deasserted mid-frame: the current frame completes normally.
- `estimated_noise_ready` in the same cycle as an `rvalid`: the beat is counted and the transition still occurs.
- `rvalid` outside NE_RUN and `rvalid_2` outside W_STATS/W_CALC are ignored.
- `overrun` and `seq_error` clear only on reset.

## Timing
- **Reset:** all outputs 0, `frame_count`=0, state IDLE, counters 0. Reset is asynchronous, takes effect mid-frame without completing anything, and the block restarts in IDLE.
- **Combinational outputs:** `start_data_noise_est` and `start_data_wiener` are combinational from registered state/`beat_cnt` and the same-cycle `rvalid`/`rvalid_2`. They are therefore aligned with the first data beat of each block.
- **Registered outputs:** all other outputs are Moore decodes of registered state or registered flags.
- **Frame start latency:** frame-ready pulse to `start_of_frame_noise_estimation` is 1 cycle.
- **Noise-ready latency:** `estimated_noise_ready` to `start_of_frame_wiener` is 1 cycle.
- **Last-beat latency:** last calc beat to `frame_done` is 1 cycle.
- **Back-to-back frames:** after DONE, IDLE needs 1 cycle, so a new frame can start 2 cycles after the last calc beat.

## Test plan
- **Nominal frame:** `blocks_per_frame`=4, SPB=64; pulse frame-ready, feed 256 `rvalid`, pulse noise-ready, feed 512 `rvalid_2`. Required: 4 `start_data_noise_est`, at beats 0/64/128/192; 4 `start_data_wiener`; stats and calc passes alternate at 64 beats each; `frame_done` exactly 1 cycle after beat 512; `frame_count`=1.
- **Overrun:** second frame-ready pulse during W_CALC → `overrun`=1; first frame still yields 1 `frame_done`; no second frame starts.
- **Zero blocks:** `blocks_per_frame`=0 with frame-ready → `seq_error`=1, `busy` stays 0.
- **Early end of frame:** `end_of_frame_wiener` during the block-2 stats pass → DONE next cycle, `seq_error`=1, `frame_count`+1.
- **Gapped beats and simultaneity:** `rvalid` toggled randomly 50%; `estimated_noise_ready` coincident with a beat. Required: `start_data_*` still exactly on counted beat 0 of each block; transition to W_SOF 1 cycle later.
- **Reset mid-frame:** `rst_n` low in W_STATS → all outputs 0 immediately; a following frame runs nominally with `frame_count` counting from 0.

Source files
------------

// File: rtl/denoise_frame_sequencer.sv
// Frame-level sequencer for the noise-estimation + Wiener denoising pipeline:
// noise pass over all blocks, then alternating stats/calc passes per block.
module denoise_frame_sequencer #(
    parameter int BLOCK_SIZE = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [31:0]          blocks_per_frame,
    input  logic                 frame_ready_for_noise_est,
    input  logic                 rvalid,
    input  logic                 estimated_noise_ready,
    input  logic                 rvalid_2,
    input  logic                 end_of_frame_wiener,
    output logic                 noise_estimation_en,
    output logic                 start_of_frame_noise_estimation,
    output logic                 start_data_noise_est,
    output logic                 start_of_frame_wiener,
    output logic                 start_data_wiener,
    output logic                 wiener_block_stats_en,
    output logic                 wiener_calc_en,
    output logic                 busy,
    output logic                 frame_done,
    output logic [CNT_WIDTH-1:0] frame_count,
    output logic                 overrun,
    output logic                 seq_error
);

    localparam int SPB = BLOCK_SIZE * BLOCK_SIZE;
    localparam int BW  = (SPB > 1) ? $clog2(SPB) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(SPB - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        NE_SOF  = 3'd1,
        NE_RUN  = 3'd2,
        W_SOF   = 3'd3,
        W_STATS = 3'd4,
        W_CALC  = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [BW-1:0]          beat_cnt_r;
    logic [31:0]            blk_cnt_r;
    logic [31:0]            nblk_r;
    logic [CNT_WIDTH-1:0]   frame_count_r;
    logic                   overrun_r;
    logic                   seq_error_r;

    logic                   start_frame_s;
    logic                   zero_blk_s;
    logic                   last_beat_s;
    logic                   last_blk_s;
    logic                   final_beat_s;
    logic                   early_eof_s;

    assign start_frame_s = (state_r == IDLE) && enable && frame_ready_for_noise_est;
    assign zero_blk_s    = start_frame_s && (blocks_per_frame == 32'd0);
    assign last_beat_s   = rvalid_2 && (beat_cnt_r == LAST_BEAT);
    assign last_blk_s    = (blk_cnt_r == (nblk_r - 32'd1));
    assign final_beat_s  = (state_r == W_CALC) && last_beat_s && last_blk_s;
    // An end-of-frame on the final calc beat is the normal completion, not an error.
    assign early_eof_s   = end_of_frame_wiener && !final_beat_s &&
                           ((state_r == W_STATS) || (state_r == W_CALC));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_frame_s && !zero_blk_s) begin
                    state_s = NE_SOF;
                end else begin
                    state_s = IDLE;
                end
            end
            NE_SOF: state_s = NE_RUN;
            NE_RUN: begin
                if (estimated_noise_ready) begin
                    state_s = W_SOF;
                end else begin
                    state_s = NE_RUN;
                end
            end
            W_SOF: state_s = W_STATS;
            W_STATS: begin
                if (early_eof_s) begin
                    state_s = DONE;
                end else if (last_beat_s) begin
                    state_s = W_CALC;
                end else begin
                    state_s = W_STATS;
                end
            end
            W_CALC: begin
                if (early_eof_s || final_beat_s) begin
                    state_s = DONE;
                end else if (last_beat_s) begin
                    state_s = W_STATS;
                end else begin
                    state_s = W_CALC;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Beat/block counters and latched block count; beat_cnt wraps modulo SPB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_r <= '0;
            blk_cnt_r  <= 32'd0;
            nblk_r     <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_frame_s) begin
                        nblk_r <= blocks_per_frame;
                    end
                end
                NE_SOF, W_SOF: begin
                    beat_cnt_r <= '0;
                    blk_cnt_r  <= 32'd0;
                end
                NE_RUN: begin
                    if (rvalid) begin
                        beat_cnt_r <= beat_cnt_r + BW'(1);
                    end
                end
                W_STATS: begin
                    if (rvalid_2) begin
                        beat_cnt_r <= beat_cnt_r + BW'(1);
                    end
                end
                W_CALC: begin
                    if (rvalid_2) begin
                        beat_cnt_r <= beat_cnt_r + BW'(1);
                        if (beat_cnt_r == LAST_BEAT) begin
                            blk_cnt_r <= blk_cnt_r + 32'd1;
                        end
                    end
                end
                default: begin
                    beat_cnt_r <= beat_cnt_r;
                end
            endcase
        end
    end

    // Sticky error flags and completed-frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_r     <= 1'b0;
            seq_error_r   <= 1'b0;
            frame_count_r <= '0;
        end else begin
            if (frame_ready_for_noise_est && (state_r != IDLE)) begin
                overrun_r <= 1'b1;
            end
            if (zero_blk_s || early_eof_s) begin
                seq_error_r <= 1'b1;
            end
            if (state_r == DONE) begin
                frame_count_r <= frame_count_r + CNT_WIDTH'(1);
            end
        end
    end

    // The ready pulse arrives in NE_RUN and is absorbed in W_SOF, so the gate stays open there.
    assign noise_estimation_en             = (state_r == NE_SOF) || (state_r == NE_RUN) ||
                                             (state_r == W_SOF);
    assign start_of_frame_noise_estimation = (state_r == NE_SOF);
    assign start_data_noise_est            = (state_r == NE_RUN) && rvalid && (beat_cnt_r == '0);
    assign start_of_frame_wiener           = (state_r == W_SOF);
    assign start_data_wiener               = (state_r == W_STATS) && rvalid_2 && (beat_cnt_r == '0);
    assign wiener_block_stats_en           = (state_r == W_STATS);
    assign wiener_calc_en                  = (state_r == W_CALC);
    assign busy                            = (state_r != IDLE);
    assign frame_done                      = (state_r == DONE);
    assign frame_count                     = frame_count_r;
    assign overrun                         = overrun_r;
    assign seq_error                       = seq_error_r;

endmodule

// File: tb/tb_denoise_frame_sequencer.sv
// Scoreboard bench: the driver pushes expected strobe events (kind, cycle)
// derived from beat indices; a negedge monitor pops them as the DUT strobes.
module tb_denoise_frame_sequencer;

    localparam int SPB = 64;
    localparam int K_SOFNE = 1, K_SDNE = 2, K_SOFW = 3, K_SDW = 4, K_DONE = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] blocks_per_frame = 32'd0;
    logic        frame_ready_for_noise_est = 1'b0;
    logic        rvalid = 1'b0;
    logic        estimated_noise_ready = 1'b0;
    logic        rvalid_2 = 1'b0;
    logic        end_of_frame_wiener = 1'b0;
    logic        noise_estimation_en, start_of_frame_noise_estimation, start_data_noise_est;
    logic        start_of_frame_wiener, start_data_wiener, wiener_block_stats_en, wiener_calc_en;
    logic        busy, frame_done, overrun, seq_error;
    logic [15:0] frame_count;

    typedef struct { int kind; int cyc; } evt_t;
    evt_t exp_q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   exp_frames = 0;

    denoise_frame_sequencer dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .blocks_per_frame(blocks_per_frame),
        .frame_ready_for_noise_est(frame_ready_for_noise_est), .rvalid(rvalid),
        .estimated_noise_ready(estimated_noise_ready), .rvalid_2(rvalid_2),
        .end_of_frame_wiener(end_of_frame_wiener), .noise_estimation_en(noise_estimation_en),
        .start_of_frame_noise_estimation(start_of_frame_noise_estimation),
        .start_data_noise_est(start_data_noise_est), .start_of_frame_wiener(start_of_frame_wiener),
        .start_data_wiener(start_data_wiener), .wiener_block_stats_en(wiener_block_stats_en),
        .wiener_calc_en(wiener_calc_en), .busy(busy), .frame_done(frame_done),
        .frame_count(frame_count), .overrun(overrun), .seq_error(seq_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc > 60000) begin
            $display("FAIL watchdog: cycle %0d exceeded budget 60000", cyc);
            $fatal(1);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int c);
        evt_t e;
        e.kind = kind;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic take(input int kind, input string name);
        evt_t e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected %s at cycle %0d", name, cyc);
        end else begin
            e = exp_q.pop_front();
            check({name, " kind"}, 64'(kind), 64'(e.kind));
            check({name, " cycle"}, 64'(cyc), 64'(e.cyc));
        end
    endtask

    // Monitor: every strobe the DUT raises must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (start_of_frame_noise_estimation) take(K_SOFNE, "sof_noise");
            if (start_data_noise_est)            take(K_SDNE, "start_data_noise");
            if (start_of_frame_wiener)           take(K_SOFW, "sof_wiener");
            if (start_data_wiener)               take(K_SDW, "start_data_wiener");
            if (frame_done)                      take(K_DONE, "frame_done");
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        frame_ready_for_noise_est = 1'b0;
        rvalid = 1'b0;
        rvalid_2 = 1'b0;
        estimated_noise_ready = 1'b0;
        end_of_frame_wiener = 1'b0;
    endtask

    function automatic logic [11:0] all_outs();
        return {noise_estimation_en, start_of_frame_noise_estimation, start_data_noise_est,
                start_of_frame_wiener, start_data_wiener, wiener_block_stats_en,
                wiener_calc_en, busy, frame_done, overrun, seq_error, |frame_count};
    endfunction

    // One frame. eof_at/ovr_at are wiener beat indices (-1 = none); stop_at aborts
    // the frame after that many wiener beats without completing it.
    task automatic run_frame(input int nblk, input bit gap, input int eof_at,
                             input int ovr_at, input int stop_at);
        int k, j, total;
        next_cycle();
        enable = 1'b1;
        blocks_per_frame = 32'(nblk);
        frame_ready_for_noise_est = 1'b1;
        push(K_SOFNE, cyc + 1);
        next_cycle();
        k = 0;
        while (k < nblk * SPB) begin
            next_cycle();
            if (gap) rvalid_2 = 1'($urandom_range(1, 0));
            if (!gap || $urandom_range(1, 0) == 1) begin
                rvalid = 1'b1;
                if (k % SPB == 0) push(K_SDNE, cyc);
                k++;
                if (gap && k == nblk * SPB) begin
                    estimated_noise_ready = 1'b1;
                    push(K_SOFW, cyc + 1);
                end
            end
        end
        if (!gap) begin
            next_cycle();
            estimated_noise_ready = 1'b1;
            push(K_SOFW, cyc + 1);
        end
        next_cycle();
        if (gap) rvalid_2 = 1'($urandom_range(1, 0));
        total = 2 * nblk * SPB;
        j = 0;
        while (j < total && j != stop_at) begin
            next_cycle();
            if (gap) rvalid = 1'($urandom_range(1, 0));
            if (gap) enable = 1'($urandom_range(1, 0));
            if (gap && $urandom_range(1, 0) == 1) continue;
            check("stats_en level", 64'(wiener_block_stats_en), 64'(((j / SPB) % 2) == 0));
            check("calc_en level", 64'(wiener_calc_en), 64'(((j / SPB) % 2) == 1));
            rvalid_2 = 1'b1;
            if (j % (2 * SPB) == 0) push(K_SDW, cyc);
            if (j == ovr_at) frame_ready_for_noise_est = 1'b1;
            if (j == eof_at) begin
                end_of_frame_wiener = 1'b1;
                push(K_DONE, cyc + 1);
                exp_frames++;
                break;
            end
            j++;
            if (j == total) begin
                end_of_frame_wiener = 1'b1;
                push(K_DONE, cyc + 1);
                exp_frames++;
            end
        end
        if (stop_at < 0) begin
            next_cycle();
            next_cycle();
            check("busy after frame", 64'(busy), 64'd0);
            check("frame_count", 64'(frame_count), 64'(exp_frames & 32'hFFFF));
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", 64'(all_outs()), 64'd0);
        rst_n = 1'b1;

        // Nominal frame, 4 blocks
        run_frame(4, 1'b0, -1, -1, -1);
        check("nominal seq_error", 64'(seq_error), 64'd0);
        check("nominal overrun", 64'(overrun), 64'd0);

        // Gapped beats, coincident noise-ready, random enable drop mid-frame
        for (int f = 0; f < 3; f++) run_frame(int'($urandom_range(3, 1)), 1'b1, -1, -1, -1);
        check("gapped seq_error", 64'(seq_error), 64'd0);

        // Overrun during calc pass of block 0; no second frame may start
        run_frame(2, 1'b0, -1, SPB + 3, -1);
        check("overrun flag", 64'(overrun), 64'd1);
        repeat (4) next_cycle();
        check("no queued frame", 64'(busy), 64'd0);

        // Early end of frame during block-2 stats pass
        run_frame(4, 1'b0, 4 * SPB + 5, -1, -1);
        check("early eof seq_error", 64'(seq_error), 64'd1);

        // Reset asserted mid stats pass
        run_frame(2, 1'b0, -1, -1, 10);
        next_cycle();
        rst_n = 1'b0;
        #1;
        check("async reset outputs", 64'(all_outs()), 64'd0);
        exp_q.delete();
        exp_frames = 0;
        next_cycle();
        rst_n = 1'b1;
        run_frame(4, 1'b0, -1, -1, -1);
        check("post-reset flags", 64'({overrun, seq_error}), 64'd0);

        // Frame-ready with enable low is ignored entirely
        next_cycle();
        enable = 1'b0;
        blocks_per_frame = 32'd0;
        frame_ready_for_noise_est = 1'b1;
        next_cycle();
        next_cycle();
        check("enable low busy", 64'(busy), 64'd0);
        check("enable low seq_error", 64'(seq_error), 64'd0);

        // Zero blocks per frame
        enable = 1'b1;
        frame_ready_for_noise_est = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            check("zero blk busy", 64'(busy), 64'd0);
        end
        check("zero blk seq_error", 64'(seq_error), 64'd1);
        check("zero blk frame_count", 64'(frame_count), 64'(exp_frames));

        check("pending events", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
